// File: rtl/alu_issue_stage.sv
// Decode/issue stage for the 8-op ALU: register file, operand fetch with writeback
// bypass, busy-bit scoreboard for RAW hazards and a one-entry registered operand bundle.
module alu_issue_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned SB_EN  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_valid,
    input  logic [31:0]       inst,
    output logic              inst_ready,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] ex_in1,
    output logic [DATA_W-1:0] ex_in2,
    output logic [IMM_W-1:0]  ex_imm,
    output logic [4:0]        ex_sh,
    output logic [4:0]        ex_aluop,
    output logic [4:0]        ex_rd,
    output logic              ex_illegal
);

    logic [DATA_W-1:0] rf_q [32];
    logic [31:0]       busy_q, busy_d;

    logic              ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0] ex_in1_q, ex_in2_q;
    logic [IMM_W-1:0]  ex_imm_q;
    logic [4:0]        ex_sh_q, ex_aluop_q, ex_rd_q;
    logic              ex_illegal_q;

    // Instruction fields
    logic [4:0] op, rd, rs, rt, sh;
    logic       illegal, is_itype, uses_rt;
    logic [IMM_W-1:0] imm;

    assign op       = inst[31:27];
    assign rd       = inst[26:22];
    assign rs       = inst[21:17];
    assign illegal  = (op[4:3] != 2'b00);
    assign is_itype = (op == 5'd0) || (op == 5'd4);
    assign uses_rt  = !illegal && !is_itype;
    assign rt       = uses_rt ? inst[16:12] : 5'd0;
    assign sh       = uses_rt ? inst[11:7] : 5'd0;
    assign imm      = is_itype ? inst[IMM_W-1:0] : '0;

    // Operand read; a same-cycle writeback to a nonzero source is forwarded
    logic [DATA_W-1:0] rs_val, rt_val;
    assign rs_val = (rs == 5'd0) ? '0 : (wb_en && (wb_addr == rs)) ? wb_data : rf_q[rs];
    assign rt_val = (rt == 5'd0) ? '0 : (wb_en && (wb_addr == rt)) ? wb_data : rf_q[rt];

    // A source is blocked only if busy and not being released by this cycle's writeback
    logic rs_busy, rt_busy, hazard, accept;
    assign rs_busy = busy_q[rs] && !(wb_en && (wb_addr == rs));
    assign rt_busy = uses_rt && busy_q[rt] && !(wb_en && (wb_addr == rt));
    assign hazard  = (SB_EN != 0) && (rs_busy || rt_busy);

    assign inst_ready = !hazard && (!ex_valid_q || ex_ready);
    assign accept     = inst_valid && inst_ready;

    // Scoreboard next state: writeback clears first so a same-cycle issue set wins
    always_comb begin
        busy_d = busy_q;
        if (wb_en) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (accept && !illegal && (rd != 5'd0)) begin
            busy_d[rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Bundle valid: set on issue, dropped when consumed with nothing to replace it
    always_comb begin
        ex_valid_d = ex_valid_q;
        if (accept) begin
            ex_valid_d = 1'b1;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    // Register file write port; r0 is hardwired to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_en && (wb_addr != 5'd0)) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    // Scoreboard busy bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Operand bundle; payload only changes on issue so it holds during stall and drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_in1_q     <= '0;
            ex_in2_q     <= '0;
            ex_imm_q     <= '0;
            ex_sh_q      <= '0;
            ex_aluop_q   <= '0;
            ex_rd_q      <= '0;
            ex_illegal_q <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            if (accept) begin
                ex_in1_q     <= rs_val;
                ex_in2_q     <= uses_rt ? rt_val : '0;
                ex_imm_q     <= imm;
                ex_sh_q      <= sh;
                ex_aluop_q   <= op;
                ex_rd_q      <= rd;
                ex_illegal_q <= illegal;
            end
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_in1     = ex_in1_q;
    assign ex_in2     = ex_in2_q;
    assign ex_imm     = ex_imm_q;
    assign ex_sh      = ex_sh_q;
    assign ex_aluop   = ex_aluop_q;
    assign ex_rd      = ex_rd_q;
    assign ex_illegal = ex_illegal_q;

endmodule
